ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver.
// Synchronizes and deglitches the keyboard clock, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), folds E0/F0 prefixes into
// flags and presents each key event through a single-entry valid/ready
// output register. While an event waits unaccepted and no frame is open,
// the keyboard clock is inhibited.
//
// Handshake: key_valid and the key_* fields hold steady until a cycle with
// key_valid && key_ready; that cycle transfers the event. An event decoded
// while the register holds an untransferred one is dropped (overrun pulse).
module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] fsm_state
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_clk_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_ok, par_ok_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          byte_done, byte_err;

  logic          ext_flag, brk_flag;
  logic          is_prefix, new_event;

  // Two-flop synchronizers for both raw keyboard lines (idle high).
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN
  // consecutive differing samples; a delayed copy marks the falling edge.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

  // Frame FSM state and datapath registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_ok  <= par_ok_n;
      to_cnt  <= to_cnt_n;
    end
  end

  // Frame FSM next state: deframing on each filtered fall, plus timeout abort.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_ok_n  = par_ok;
    to_cnt_n  = to_cnt + TW'(1);
    byte_done = 1'b0;
    byte_err  = 1'b0;

    if (state == IDLE || fall) begin
      to_cnt_n = '0;
    end

    case (state)
      IDLE: begin
        if (fall && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {dat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_n = ^{shift, dat_s2};
          state_n  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (par_ok && dat_s2) begin
            byte_done = 1'b1;
          end else begin
            byte_err = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n  = IDLE;
      byte_err = 1'b1;
    end
  end

  assign is_prefix = (shift == 8'hE0) || (shift == 8'hF0);
  assign new_event = byte_done && !is_prefix;

  // Prefix flags and error pulse: prefixes arm flags, events and errors clear them.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= byte_err;
      if (byte_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_done) begin
        if (shift == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  // Single-entry output register with overrun detection.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (new_event) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= shift;
          key_ext   <= ext_flag;
          key_break <= brk_flag;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  // Inhibit the keyboard only between frames while an event is stuck.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ps2_clk_oe <= 1'b0;
    end else begin
      ps2_clk_oe <= key_valid && !key_ready && (state == IDLE);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Testbench for ps2_key_rx: drives PS/2 frames, scoreboards key events.
module tb_ps2_key_rx;

  localparam int FILT = 8;
  localparam int TMO  = 400;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid, key_ready;
  logic       frame_err, overrun;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  logic [9:0] exp_q[$];

  ps2_key_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fsm_state  (fsm_state)
  );

  // Clock and watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every transferred event is checked against the queue head.
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (overrun) ovr_seen++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0)
          check_val("evt_unexpected", {22'd0, key_ext, key_break, key_code}, 32'hFFFF_FFFF);
        else
          check_val("evt", {22'd0, key_ext, key_break, key_code}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  // One PS/2 bit: data set up, 20-cycle low phase, 10-cycle high tail.
  // With lat set, checks key_valid rises exactly one cycle after the filtered fall.
  task automatic send_bit(input logic b, input logic lat);
    ps2_data = b;
    wait_ticks(10);
    ps2_clk = 1'b0;
    if (lat) begin
      wait_ticks(FILT + 2);
      @(negedge sys_clk);
      check_val("lat_before", key_valid, 0);
      tick();
      @(negedge sys_clk);
      check_val("lat_at", key_valid, 1);
      wait_ticks(9);
    end else begin
      wait_ticks(20);
    end
    ps2_clk = 1'b1;
    wait_ticks(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b,
                            input logic lat);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ par_flip, 1'b0);
    send_bit(stop_b, lat);
    ps2_data = 1'b1;
    wait_ticks(20);
  endtask

  initial begin
    reset     = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    key_ready = 1'b1;
    wait_ticks(3);
    check_val("rst_valid", key_valid, 0);
    check_val("rst_code", key_code, 8'h00);
    check_val("rst_oe", ps2_clk_oe, 0);
    check_val("rst_ferr", frame_err, 0);
    check_val("rst_state", fsm_state, 0);
    reset = 1'b0;
    wait_ticks(5);

    // Plain make code with latency check
    exp_q.push_back({2'b00, 8'h16});
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    check_val("t1_err", err_seen, 0);

    // Prefix sequences
    exp_q.push_back({2'b01, 8'h16});
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check_val("t2_q_empty", exp_q.size(), 0);

    // Parity error clears the pending break flag
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h16, 1'b1, 1'b1, 1'b0);
    check_val("t3_err", err_seen, 1);
    exp_q.push_back({2'b00, 8'h16});
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    check_val("t3_q_empty", exp_q.size(), 0);

    // Timeout after start plus 4 bits
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    ps2_data = 1'b1;
    wait_ticks(TMO + 50);
    check_val("t4_err", err_seen, 2);
    check_val("t4_idle", fsm_state, 0);
    exp_q.push_back({2'b00, 8'h1E});
    send_frame(8'h1E, 1'b0, 1'b1, 1'b0);

    // Bad stop bit
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    check_val("stop_err", err_seen, 3);

    // Short low glitch with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_ticks(3);
    ps2_clk = 1'b1;
    wait_ticks(20);
    check_val("glitch_idle", fsm_state, 0);
    ps2_data = 1'b1;
    wait_ticks(5);

    // Held event, inhibit and overrun
    key_ready = 1'b0;
    exp_q.push_back({2'b00, 8'h16});
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    check_val("t5_oe", ps2_clk_oe, 1);
    check_val("t5_valid", key_valid, 1);
    send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
    check_val("t5_ovr", ovr_seen, 1);
    check_val("t5_code", key_code, 8'h16);
    check_val("t5_oe2", ps2_clk_oe, 1);
    key_ready = 1'b1;
    tick();
    @(negedge sys_clk);
    check_val("t5_drop", key_valid, 0);
    check_val("t5_q_empty", exp_q.size(), 0);

    // Asynchronous reset mid-DATA
    key_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_val("t6_held", key_code, 8'h1C);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check_val("t6_valid", key_valid, 0);
    check_val("t6_code", key_code, 8'h00);
    check_val("t6_ext", key_ext, 0);
    check_val("t6_brk", key_break, 0);
    check_val("t6_oe", ps2_clk_oe, 0);
    check_val("t6_state", fsm_state, 0);
    check_val("t6_ovr", overrun, 0);
    ps2_data = 1'b1;
    wait_ticks(5);
    reset = 1'b0;
    key_ready = 1'b1;
    wait_ticks(5);
    exp_q.push_back({2'b00, 8'h45});
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);

    wait_ticks(20);
    check_val("final_q_empty", exp_q.size(), 0);
    check_val("final_err", err_seen, 3);
    check_val("final_ovr", ovr_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
